// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan decoder.
//   - Active-low segment patterns for hex 0..F (bit0=a .. bit5=f, bit6=g)
//   - SEG_BLANK: all segments off
//   - state_e: capture state machine encoding
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational inverse of the hex-to-segment encoder.
// Ports:
//   seg   in  7  active-low segment pattern
//   val   out 4  decoded nibble (0 for blank or illegal patterns)
//   err   out 1  pattern is neither a hex digit nor blank
//   blank out 1  pattern is all segments off
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] val,
  output logic       err,
  output logic       blank
);

  always_comb begin
    val   = 4'h0;
    err   = 1'b0;
    blank = 1'b0;
    case (seg)
      SEG_0:     val = 4'h0;
      SEG_1:     val = 4'h1;
      SEG_2:     val = 4'h2;
      SEG_3:     val = 4'h3;
      SEG_4:     val = 4'h4;
      SEG_5:     val = 4'h5;
      SEG_6:     val = 4'h6;
      SEG_7:     val = 4'h7;
      SEG_8:     val = 4'h8;
      SEG_9:     val = 4'h9;
      SEG_A:     val = 4'hA;
      SEG_B:     val = 4'hB;
      SEG_C:     val = 4'hC;
      SEG_D:     val = 4'hD;
      SEG_E:     val = 4'hE;
      SEG_F:     val = 4'hF;
      SEG_BLANK: blank = 1'b1;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: monitors multiplexed active-low seven-segment lines, waits for each
// digit to settle, decodes it back to a nibble and reports complete sweeps as frames.
// Ports:
//   Clk, Reset   clock; asynchronous active-high reset
//   seg_n        active-low segment lines (bit0=a .. bit6=g)
//   an_n         active-low digit enables
//   digit_valid  one-cycle pulse per captured digit; digit_idx/val/err/blank describe it
//   frame_valid  one-cycle pulse once every digit has been captured since the last frame
//   frame_data   nibble of digit i in bits [4i+3:4i]; frame_err flags any error in frame
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [6:0]                    seg_n,
  input  logic [NUM_DIGITS-1:0]         an_n,
  output logic                          digit_valid,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic [3:0]                    digit_val,
  output logic                          digit_err,
  output logic                          digit_blank,
  output logic                          frame_valid,
  output logic [4*NUM_DIGITS-1:0]       frame_data,
  output logic                          frame_err
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  // Two-flop synchronizer plus one extra stage holding the previous synchronized sample.
  logic [6:0]            seg_meta, s_seg, seg_prev;
  logic [NUM_DIGITS-1:0] an_meta, s_an, an_prev;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      seg_meta <= '1;
      s_seg    <= '1;
      seg_prev <= '1;
      an_meta  <= '1;
      s_an     <= '1;
      an_prev  <= '1;
    end else begin
      seg_meta <= seg_n;
      s_seg    <= seg_meta;
      seg_prev <= s_seg;
      an_meta  <= an_n;
      s_an     <= an_meta;
      an_prev  <= s_an;
    end
  end

  logic [3:0] dec_val;
  logic       dec_err, dec_blank;

  seg7_pattern_decode u_decode (
    .seg   (s_seg),
    .val   (dec_val),
    .err   (dec_err),
    .blank (dec_blank)
  );

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            an_onehot, same, capture;
  logic [IdxW-1:0] active_idx;

  always_comb begin
    an_onehot  = ($countones(~s_an) == 1);
    same       = (s_an == an_prev) && (s_seg == seg_prev);
    active_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!s_an[i]) active_idx = IdxW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (an_onehot) begin
          state_d = SETTLE;
          cnt_d   = CntW'(1);
        end
      end
      SETTLE: begin
        if (!an_onehot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          cnt_d = CntW'(1);
        end else begin
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!an_onehot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          state_d = SETTLE;
          cnt_d   = CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame accumulation. A frame completing this cycle releases the mask before the
  // current capture is merged, so a simultaneous capture starts the next frame.
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    err_acc_q, err_acc_d;
  logic                    frame_done;
  logic [3:0]              cap_val;

  always_comb begin
    frame_done = &mask_q;
    cap_val    = (dec_err || dec_blank) ? 4'h0 : dec_val;
    mask_d     = frame_done ? '0 : mask_q;
    err_acc_d  = frame_done ? 1'b0 : err_acc_q;
    if (capture) begin
      mask_d[active_idx] = 1'b1;
      err_acc_d          = err_acc_d | dec_err;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      digits_q    <= '0;
      mask_q      <= '0;
      err_acc_q   <= 1'b0;
      digit_valid <= 1'b0;
      digit_idx   <= '0;
      digit_val   <= 4'h0;
      digit_err   <= 1'b0;
      digit_blank <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_err   <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      err_acc_q   <= err_acc_d;
      digit_valid <= capture;
      frame_valid <= frame_done;
      if (capture) begin
        digits_q[4*active_idx +: 4] <= cap_val;
        digit_idx   <= active_idx;
        digit_val   <= cap_val;
        digit_err   <= dec_err;
        digit_blank <= dec_blank;
      end
      if (frame_done) begin
        frame_data <= digits_q;
        frame_err  <= err_acc_q;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus randomized scanning, all outputs
// compared every cycle against a sample-history reference model.
module tb_seg7_scan_decoder;

  localparam int N = 4;
  localparam int S = 16;

  logic           Clk   = 1'b0;
  logic           Reset = 1'b1;
  logic [6:0]     seg_n = 7'h7F;
  logic [N-1:0]   an_n  = '1;
  logic           digit_valid, digit_err, digit_blank, frame_valid, frame_err;
  logic [1:0]     digit_idx;
  logic [3:0]     digit_val;
  logic [4*N-1:0] frame_data;

  always #5 Clk = ~Clk;

  seg7_scan_decoder #(
    .NUM_DIGITS    (N),
    .STABLE_CYCLES (S)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digit_valid (digit_valid),
    .digit_idx   (digit_idx),
    .digit_val   (digit_val),
    .digit_err   (digit_err),
    .digit_blank (digit_blank),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_err   (frame_err)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [6:0] legal [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: raw-sample delay line, run length of identical samples,
  // expected outputs and frame bookkeeping.
  logic [6:0]     dl_seg [2];
  logic [N-1:0]   dl_an  [2];
  logic [6:0]     lv_seg;
  logic [N-1:0]   lv_an;
  int             run;
  logic           m_dv, m_err, m_blank, m_fv, m_ferr;
  int             m_idx;
  logic [3:0]     m_val;
  logic [4*N-1:0] m_fdata;
  logic [3:0]     m_digits [N];
  logic [N-1:0]   m_mask;
  logic           m_acc, m_pending;

  int             digits_seen = 0;
  int             frames_seen = 0;
  logic [4*N-1:0] last_frame  = '0;
  logic           last_ferr   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      dl_seg[i] = '1;
      dl_an[i]  = '1;
    end
    lv_seg = '1; lv_an = '1; run = 1;
    m_dv = 0; m_idx = 0; m_val = 0; m_err = 0; m_blank = 0;
    m_fv = 0; m_fdata = '0; m_ferr = 0;
    for (int i = 0; i < N; i++) m_digits[i] = 4'h0;
    m_mask = '0; m_acc = 0; m_pending = 0;
  endtask

  task automatic decode(input logic [6:0] p, output logic [3:0] v, output logic e,
                        output logic b);
    v = 4'h0; e = 1'b1; b = 1'b0;
    if (p == 7'h7F) begin
      e = 1'b0; b = 1'b1;
    end
    for (int i = 0; i < 16; i++) begin
      if (legal[i] == p) begin
        v = 4'(i); e = 1'b0;
      end
    end
  endtask

  // One rising edge of the model: the logic sees the sample taken two edges earlier.
  task automatic model_edge();
    logic [6:0]   v_seg;
    logic [N-1:0] v_an;
    int           lows, idx;
    logic [3:0]   dv;
    logic         de, db;
    if (Reset) begin
      model_reset();
      return;
    end
    v_seg = dl_seg[1];
    v_an  = dl_an[1];
    if (v_seg == lv_seg && v_an == lv_an) begin
      if (run <= S) run++;
    end else begin
      run = 1;
    end
    lv_seg = v_seg; lv_an = v_an;
    dl_seg[1] = dl_seg[0]; dl_an[1] = dl_an[0];
    dl_seg[0] = seg_n;     dl_an[0] = an_n;
    m_dv = 0; m_fv = 0;
    if (m_pending) begin
      m_fv = 1;
      for (int i = 0; i < N; i++) m_fdata[4*i +: 4] = m_digits[i];
      m_ferr = m_acc;
      m_mask = '0; m_acc = 0; m_pending = 0;
    end
    lows = 0; idx = 0;
    for (int i = 0; i < N; i++) begin
      if (!v_an[i]) begin
        lows++; idx = i;
      end
    end
    if (lows == 1 && run == S) begin
      decode(v_seg, dv, de, db);
      m_dv = 1; m_idx = idx; m_val = dv; m_err = de; m_blank = db;
      m_digits[idx] = dv;
      m_mask[idx] = 1'b1;
      m_acc = m_acc | de;
      if (m_mask == '1) m_pending = 1;
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_eq("digit_valid", 32'(digit_valid), 32'(m_dv));
    check_eq("digit_idx", 32'(digit_idx), 32'(m_idx));
    check_eq("digit_val", 32'(digit_val), 32'(m_val));
    check_eq("digit_err", 32'(digit_err), 32'(m_err));
    check_eq("digit_blank", 32'(digit_blank), 32'(m_blank));
    check_eq("frame_valid", 32'(frame_valid), 32'(m_fv));
    check_eq("frame_data", 32'(frame_data), 32'(m_fdata));
    check_eq("frame_err", 32'(frame_err), 32'(m_ferr));
    if (digit_valid) digits_seen++;
    if (frame_valid) begin
      frames_seen++;
      last_frame = frame_data;
      last_ferr  = frame_err;
    end
  endtask

  task automatic hold(input logic [N-1:0] a, input logic [6:0] s, input int n);
    an_n = a; seg_n = s;
    repeat (n) step();
  endtask

  task automatic do_reset();
    an_n = '1; seg_n = 7'h7F; Reset = 1'b1;
    repeat (3) step();
    Reset = 1'b0;
  endtask

  task automatic cycles_to_valid(output int c);
    c = 0;
    do begin
      step();
      c++;
    end while (!digit_valid && c < 100);
  endtask

  task automatic sweep(input logic [27:0] pats, input int first, input int last);
    logic [N-1:0] a;
    for (int i = first; i <= last; i++) begin
      a = '1; a[i] = 1'b0;
      hold(a, pats[7*i +: 7], 20);
    end
  endtask

  initial begin
    int c, d0, f0;
    logic [N-1:0] a;
    logic [6:0] s;
    model_reset();
    do_reset();
    check_eq("reset_frame_data", 32'(frame_data), 32'h0);
    check_eq("reset_digit_valid", 32'(digit_valid), 32'h0);

    // Single stable digit: capture latency.
    an_n = 4'b1110; seg_n = 7'h40;
    cycles_to_valid(c);
    check_eq("first_latency", 32'(c), 32'd18);
    check_eq("first_idx", 32'(digit_idx), 32'd0);
    check_eq("first_val", 32'(digit_val), 32'd0);
    check_eq("first_err", 32'(digit_err), 32'd0);

    // Full sweep produces one frame.
    do_reset();
    d0 = digits_seen; f0 = frames_seen;
    sweep({7'h0E, 7'h30, 7'h24, 7'h79}, 0, 3);
    hold('1, 7'h7F, 5);
    check_eq("sweep_digits", 32'(digits_seen - d0), 32'd4);
    check_eq("sweep_frames", 32'(frames_seen - f0), 32'd1);
    check_eq("sweep_data", 32'(last_frame), 32'hF321);
    check_eq("sweep_ferr", 32'(last_ferr), 32'd0);

    // Unsettled segments never capture; a long hold captures once.
    d0 = digits_seen;
    for (int k = 0; k < 6; k++) hold(4'b1101, (k % 2) ? 7'h30 : 7'h24, 10);
    check_eq("toggle_no_cap", 32'(digits_seen - d0), 32'd0);
    hold(4'b1101, 7'h24, 20);
    check_eq("toggle_then_hold", 32'(digits_seen - d0), 32'd1);

    // Non one-hot anodes never capture.
    d0 = digits_seen;
    hold(4'b1100, 7'h19, 30);
    hold(4'b1111, 7'h19, 30);
    check_eq("multi_anode_no_cap", 32'(digits_seen - d0), 32'd0);
    an_n = 4'b1011; seg_n = 7'h12;
    cycles_to_valid(c);
    check_eq("onehot_latency", 32'(c), 32'd18);
    check_eq("onehot_idx", 32'(digit_idx), 32'd2);
    check_eq("onehot_val", 32'(digit_val), 32'd5);

    // Illegal pattern flags only its own frame; blank is not an error.
    do_reset();
    sweep({7'h0E, 7'h55, 7'h24, 7'h79}, 0, 3);
    hold('1, 7'h7F, 3);
    check_eq("err_frame_ferr", 32'(last_ferr), 32'd1);
    check_eq("err_frame_data", 32'(last_frame), 32'hF021);
    sweep({7'h0E, 7'h30, 7'h24, 7'h79}, 0, 3);
    hold('1, 7'h7F, 3);
    check_eq("clean_frame_ferr", 32'(last_ferr), 32'd0);
    hold(4'b1110, 7'h7F, 20);
    check_eq("blank_flag", 32'(digit_blank), 32'd1);
    check_eq("blank_no_err", 32'(digit_err), 32'd0);

    // Reset discards a partial frame.
    do_reset();
    sweep({7'h0E, 7'h30, 7'h24, 7'h79}, 0, 2);
    do_reset();
    f0 = frames_seen;
    sweep({7'h0E, 7'h30, 7'h24, 7'h79}, 3, 3);
    hold('1, 7'h7F, 3);
    check_eq("partial_discarded", 32'(frames_seen - f0), 32'd0);
    sweep({7'h0E, 7'h30, 7'h24, 7'h79}, 0, 2);
    hold('1, 7'h7F, 3);
    check_eq("after_reset_frames", 32'(frames_seen - f0), 32'd1);

    // Randomized scanning.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      if ($urandom_range(0, 9) == 0) begin
        a = 4'($urandom_range(0, 15));
      end else begin
        a = '1; a[$urandom_range(0, N - 1)] = 1'b0;
      end
      case ($urandom_range(0, 9))
        0:       s = 7'h7F;
        1:       s = 7'($urandom_range(0, 127));
        default: s = legal[$urandom_range(0, 15)];
      endcase
      hold(a, s, $urandom_range(1, 40));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
